binary_mul_seq: RTL and testbench

BINARY_MUL_SEQ -- requirements
Module: binary_mul_seq

---
 rtl/binary_mul_pkg.sv | 16 +
 rtl/binary_mul_abs.sv | 15 +
 rtl/binary_mul_seq.sv | 110 +++++++++++
 tb/tb_binary_mul_seq.sv | 345 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/binary_mul_pkg.sv
// Shared types for the sequential shift-add multiplier.
// Holds the FSM state encoding and the counter-width helper.
package binary_mul_pkg;

    typedef enum logic [1:0] {
        IDLE,
        CALC,
        DONE
    } state_t;

    // Counter must be able to hold the value WIDTH itself.
    function automatic int cnt_w(input int w);
        return $clog2(w + 1);
    endfunction

endpackage

// File: rtl/binary_mul_abs.sv
// Operand conditioning: magnitude and sign of one operand.
// The most negative value maps to the unsigned 2^(WIDTH-1).
module binary_mul_abs #(
    parameter int WIDTH = 8
) (
    input  logic [WIDTH-1:0] value,
    input  logic             sgn,
    output logic [WIDTH-1:0] magnitude,
    output logic             neg
);

    assign neg       = sgn & value[WIDTH-1];
    assign magnitude = neg ? ((~value) + WIDTH'(1)) : value;

endmodule

// File: rtl/binary_mul_seq.sv
// Sequential shift-add multiplier, signed or unsigned per operation.
// One step per enabled cycle, valid/ready on both sides.
module binary_mul_seq #(
    parameter int WIDTH = 8
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               en,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [WIDTH-1:0]   A,
    input  logic [WIDTH-1:0]   B,
    input  logic               sgn,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [2*WIDTH-1:0] P
);
    import binary_mul_pkg::*;

    localparam int CW = cnt_w(WIDTH);
    localparam int PW = 2 * WIDTH;

    state_t           state;
    state_t           state_n;
    logic [CW-1:0]    cnt;
    logic [PW-1:0]    acc;
    logic [PW-1:0]    mcand;
    logic [WIDTH-1:0] mplier;
    logic             sgn_q;
    logic             neg_q;
    logic [WIDTH-1:0] mag_a;
    logic [WIDTH-1:0] mag_b;
    logic             neg_a;
    logic             neg_b;
    logic             last;

    binary_mul_abs #(.WIDTH(WIDTH)) u_abs_a (
        .value    (A),
        .sgn      (sgn),
        .magnitude(mag_a),
        .neg      (neg_a)
    );

    binary_mul_abs #(.WIDTH(WIDTH)) u_abs_b (
        .value    (B),
        .sgn      (sgn),
        .magnitude(mag_b),
        .neg      (neg_b)
    );

    assign in_ready  = (state == IDLE) & en;
    assign out_valid = (state == DONE);
    assign last      = (cnt == CW'(WIDTH));

    // State register; reset wins over enable.
    always_ff @(posedge clk) begin
        if (rst)     state <= IDLE;
        else if (en) state <= state_n;
    end

    // Next-state logic for accept, step count and consume.
    always_comb begin
        state_n = state;
        unique case (state)
            IDLE:    if (in_valid) state_n = CALC;
            CALC:    if (last)     state_n = DONE;
            DONE:    if (out_ready) state_n = IDLE;
            default: state_n = IDLE;
        endcase
    end

    // Datapath: capture, shift-add steps, then signed result load.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt    <= '0;
            acc    <= '0;
            mcand  <= '0;
            mplier <= '0;
            sgn_q  <= 1'b0;
            neg_q  <= 1'b0;
            P      <= '0;
        end else if (en) begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        sgn_q  <= sgn;
                        neg_q  <= neg_a ^ neg_b;
                        mcand  <= {{WIDTH{1'b0}}, mag_a};
                        mplier <= mag_b;
                        acc    <= '0;
                        cnt    <= '0;
                    end
                end
                CALC: begin
                    if (last) begin
                        // -0 is 0 in two's complement, so no special case.
                        P <= (sgn_q & neg_q) ? ((~acc) + PW'(1)) : acc;
                    end else begin
                        if (mplier[0]) acc <= acc + mcand;
                        mcand  <= mcand << 1;
                        mplier <= mplier >> 1;
                        cnt    <= cnt + CW'(1);
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_binary_mul_seq.sv
// Self-checking bench for binary_mul_seq (WIDTH=8 and WIDTH=3).
// Results are compared with plain integer multiplication.
module tb_binary_mul_seq;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        en  = 1'b1;

    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [7:0]  a = '0;
    logic [7:0]  b = '0;
    logic        sgn = 1'b0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [15:0] p;

    logic        in_valid3 = 1'b0;
    logic        in_ready3;
    logic [2:0]  a3 = '0;
    logic [2:0]  b3 = '0;
    logic        out_valid3;
    logic        out_ready3 = 1'b0;
    logic [5:0]  p3;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    binary_mul_seq #(.WIDTH(8)) dut (
        .clk(clk), .rst(rst), .en(en),
        .in_valid(in_valid), .in_ready(in_ready),
        .A(a), .B(b), .sgn(sgn),
        .out_valid(out_valid), .out_ready(out_ready),
        .P(p)
    );

    binary_mul_seq #(.WIDTH(3)) dut3 (
        .clk(clk), .rst(rst), .en(en),
        .in_valid(in_valid3), .in_ready(in_ready3),
        .A(a3), .B(b3), .sgn(1'b0),
        .out_valid(out_valid3), .out_ready(out_ready3),
        .P(p3)
    );

    function automatic logic [15:0] model8(input logic [7:0] x,
                                           input logic [7:0] y,
                                           input logic s);
        int ix, iy;
        ix = s ? int'($signed(x)) : int'(x);
        iy = s ? int'($signed(y)) : int'(y);
        return 16'(ix * iy);
    endfunction

    // Drive one op; return product and edges from accept to out_valid.
    task automatic do_op(input logic [7:0] x, input logic [7:0] y,
                         input logic s, input bit consume,
                         output logic [15:0] res, output int lat,
                         output bit tmo);
        int w;
        tmo = 0;
        lat = 0;
        res = '0;
        w = 0;
        do begin
            @(negedge clk);
            w++;
        end while (!in_ready && w < 50);
        if (!in_ready) begin
            tmo = 1;
            return;
        end
        a = x; b = y; sgn = s; in_valid = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        a = 8'($urandom);
        b = 8'($urandom);
        sgn = 1'($urandom);
        do begin
            @(posedge clk);
            lat++;
            @(negedge clk);
        end while (!out_valid && lat < 40);
        if (!out_valid) begin
            tmo = 1;
            return;
        end
        res = p;
        if (consume) begin
            out_ready = 1'b1;
            @(posedge clk);
            #1;
            out_ready = 1'b0;
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        en = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        checks++;
        if (in_ready !== 1'b1) begin
            errors++;
            $display("FAIL reset_in_ready got %b want 1", in_ready);
        end
        checks++;
        if (out_valid !== 1'b0) begin
            errors++;
            $display("FAIL reset_out_valid got %b want 0", out_valid);
        end
        checks++;
        if (p !== 16'h0000) begin
            errors++;
            $display("FAIL reset_p got %h want 0000", p);
        end
    endtask

    task automatic test_unsigned();
        logic [15:0] r;
        int lat;
        bit tmo;
        do_op(8'd255, 8'd255, 1'b0, 1, r, lat, tmo);
        checks++;
        if (tmo || r !== 16'hFE01) begin
            errors++;
            $display("FAIL u255x255 got %h want fe01 tmo %0d", r, tmo);
        end
        checks++;
        if (lat !== 9) begin
            errors++;
            $display("FAIL u255_latency got %0d want 9", lat);
        end
    endtask

    task automatic test_signed();
        logic [7:0]  xs [3] = '{8'h80, 8'hFD, 8'h00};
        logic [7:0]  ys [3] = '{8'h80, 8'h05, 8'h80};
        logic [15:0] ex [3] = '{16'h4000, 16'hFFF1, 16'h0000};
        logic [15:0] r;
        int lat;
        bit tmo;
        for (int i = 0; i < 3; i++) begin
            do_op(xs[i], ys[i], 1'b1, 1, r, lat, tmo);
            checks++;
            if (tmo || r !== ex[i] || lat !== 9) begin
                errors++;
                $display("FAIL signed_%0d got %h lat %0d want %h lat 9",
                         i, r, lat, ex[i]);
            end
        end
    endtask

    task automatic test_random();
        logic [15:0] r;
        logic [7:0]  x, y;
        logic        s;
        int lat;
        bit tmo;
        for (int i = 0; i < 40; i++) begin
            x = 8'($urandom);
            y = 8'($urandom);
            s = 1'($urandom);
            if (i % 8 == 0) x = 8'h80;
            do_op(x, y, s, 1, r, lat, tmo);
            checks++;
            if (tmo || r !== model8(x, y, s)) begin
                errors++;
                $display("FAIL rand %h*%h s%0d got %h want %h",
                         x, y, s, r, model8(x, y, s));
            end
        end
    endtask

    task automatic test_sweep3();
        int w;
        for (int i = 0; i < 8; i++) begin
            for (int j = 0; j < 8; j++) begin
                w = 0;
                do begin
                    @(negedge clk);
                    w++;
                end while (!in_ready3 && w < 20);
                a3 = 3'(i); b3 = 3'(j); in_valid3 = 1'b1;
                @(posedge clk);
                #1;
                in_valid3 = 1'b0;
                a3 = 3'($urandom);
                b3 = 3'($urandom);
                w = 0;
                do begin
                    @(negedge clk);
                    w++;
                end while (!out_valid3 && w < 20);
                checks++;
                if (!out_valid3 || p3 !== 6'(i * j)) begin
                    errors++;
                    $display("FAIL sweep3 %0d*%0d got %0d want %0d ov %b",
                             i, j, p3, i * j, out_valid3);
                end
                out_ready3 = 1'b1;
                @(posedge clk);
                #1;
                out_ready3 = 1'b0;
            end
        end
    endtask

    task automatic test_backpressure();
        logic [15:0] r;
        int lat;
        bit tmo;
        do_op(8'd200, 8'd3, 1'b0, 0, r, lat, tmo);
        checks++;
        if (tmo || r !== 16'd600) begin
            errors++;
            $display("FAIL bp_first got %h want 0258", r);
        end
        a = 8'h33; b = 8'h05; sgn = 1'b0; in_valid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(posedge clk);
            @(negedge clk);
            checks++;
            if (p !== 16'd600 || out_valid !== 1'b1 || in_ready !== 1'b0) begin
                errors++;
                $display("FAIL bp_hold_%0d p %h ov %b ir %b want 0258 1 0",
                         i, p, out_valid, in_ready);
            end
        end
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        @(negedge clk);
        checks++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
            errors++;
            $display("FAIL bp_consume ov %b ir %b want 0 1",
                     out_valid, in_ready);
        end
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        lat = 0;
        do begin
            @(posedge clk);
            lat++;
            @(negedge clk);
        end while (!out_valid && lat < 40);
        checks++;
        if (p !== 16'h00FF || lat !== 9) begin
            errors++;
            $display("FAIL bp_second got %h lat %0d want 00ff lat 9", p, lat);
        end
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
    endtask

    task automatic test_stall();
        int lat;
        @(negedge clk);
        a = 8'd12; b = 8'd11; sgn = 1'b0; in_valid = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        a = 8'hFF; b = 8'hFF;
        lat = 0;
        do begin
            @(posedge clk);
            lat++;
            #1;
            if (lat == 3) en = 1'b0;
            if (lat == 6) en = 1'b1;
            @(negedge clk);
            if (!en) begin
                checks++;
                if (in_ready !== 1'b0 || out_valid !== 1'b0) begin
                    errors++;
                    $display("FAIL stall_hold ir %b ov %b want 0 0",
                             in_ready, out_valid);
                end
            end
        end while (!out_valid && lat < 40);
        en = 1'b1;
        checks++;
        if (p !== 16'd132 || lat !== 12) begin
            errors++;
            $display("FAIL stall got %0d lat %0d want 132 lat 12", p, lat);
        end
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
    endtask

    task automatic test_abort();
        logic [15:0] r;
        int lat;
        bit tmo;
        @(negedge clk);
        a = 8'd99; b = 8'd77; sgn = 1'b0; in_valid = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        checks++;
        if (out_valid !== 1'b0 || p !== 16'h0000 || in_ready !== 1'b1) begin
            errors++;
            $display("FAIL abort ov %b p %h ir %b want 0 0000 1",
                     out_valid, p, in_ready);
        end
        do_op(8'd7, 8'd6, 1'b0, 1, r, lat, tmo);
        checks++;
        if (tmo || r !== 16'd42 || lat !== 9) begin
            errors++;
            $display("FAIL abort_next got %0d lat %0d want 42 lat 9", r, lat);
        end
    endtask

    initial begin
        test_reset();
        test_unsigned();
        test_signed();
        test_random();
        test_sweep3();
        test_backpressure();
        test_stall();
        test_abort();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
